// File: rtl/mux_col_pkg.sv
// -----------------------------------------------------------------------------
// mux_col_pkg
//
// Shared definitions for the multiplexed-column output demultiplexer.
//   - state_t       : window-ownership state (IDLE before the first gamma
//                     reset, then alternating RUN_N1 / RUN_N2).
//   - NNET          : number of networks time-sharing the column.
//   - NO_SPIKE_BIT  : fill bit of the "no spike" time code. A stamp with every
//                     bit set (2^TRES-1) means the neuron did not fire. This
//                     is also the value at which the window time counter
//                     saturates.
//   - DEFAULT_Q / DEFAULT_TRES : default column width and time-stamp width.
// -----------------------------------------------------------------------------
package mux_col_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_N1 = 2'd1,
        RUN_N2 = 2'd2
    } state_t;

    localparam int   NNET         = 2;
    localparam int   DEFAULT_Q    = 2;
    localparam int   DEFAULT_TRES = 3;
    localparam logic NO_SPIKE_BIT = 1'b1;

endpackage : mux_col_pkg

// File: rtl/spike_capture.sv
// -----------------------------------------------------------------------------
// spike_capture
//
// Per-window sticky capture of the column's output spikes for all Q neurons.
// A neuron's latch bit sets on its first spike of the window and stays set
// until the window is committed (clr). With COLUMN_DEMUX_SPIKE_TIME_EN defined,
// the window time counter is also stamped per neuron on that first 0->1
// transition; neurons that never fire keep the all-ones "no spike" code.
//
// Ports:
//   clk     in   system clock
//   rstb    in   asynchronous active-low reset
//   clr     in   clear latch (and stamps) at the window boundary
//   en      in   capture enable (running and not in a gamma-reset cycle)
//   spikes  in   [Q]        column output spikes
//   tcount  in   [TRES]     window time counter      (macro builds only)
//   latch   out  [Q]        sticky captured spike vector
//   stamps  out  [Q][TRES]  first-spike time per neuron (macro builds only)
//
// Optional feature macro: COLUMN_DEMUX_SPIKE_TIME_EN
// -----------------------------------------------------------------------------
module spike_capture
    import mux_col_pkg::*;
#(
    parameter int Q = DEFAULT_Q
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    ,
    parameter int TRES = DEFAULT_TRES
`endif
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    clr,
    input  logic                    en,
    input  logic [Q-1:0]            spikes,
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    input  logic [TRES-1:0]         tcount,
`endif
    output logic [Q-1:0]            latch
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    ,
    output logic [Q-1:0][TRES-1:0]  stamps
`endif
);

    logic [Q-1:0] r_latch;

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples pre-edge values; blocking here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_latch <= '0;
        end else if (clr) begin
            r_latch <= '0;
        end else if (en) begin
            // Sticky OR: once a neuron fires it stays recorded for the window.
            r_latch <= r_latch | spikes;
        end
    end

    assign latch = r_latch;

`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    logic [Q-1:0]           w_first;
    logic [Q-1:0][TRES-1:0] r_stamps;

    // A stamp is taken only on the first spike: a neuron whose latch bit is
    // already set keeps its earlier time.
    assign w_first = {Q{en}} & spikes & ~r_latch;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stamps <= {(Q*TRES){NO_SPIKE_BIT}};
        end else if (clr) begin
            r_stamps <= {(Q*TRES){NO_SPIKE_BIT}};
        end else begin
            for (int q = 0; q < Q; q++) begin
                if (w_first[q]) begin
                    r_stamps[q] <= tcount;
                end
            end
        end
    end

    assign stamps = r_stamps;
`endif

endmodule : spike_capture

// File: rtl/column_output_demux.sv
// -----------------------------------------------------------------------------
// column_output_demux
//
// Demultiplexes the output of a column that alternates gamma windows between
// two networks (network 1 on even windows, network 2 on odd windows). The
// window in progress is captured sticky; at the next gamma reset it is
// committed to the owning network's held bank and that network's valid
// pulses for one cycle, aligned with the new bank value.
//
// Ports:
//   clk             in   system clock
//   rstb            in   asynchronous active-low reset
//   grst            in   gamma reset, one-cycle pulse starting each window
//   col_spikes      in   [Q] column output spikes (already clk-synchronous)
//   output_spikes1  out  [Q] network-1 committed spikes, held between commits
//   output_spikes2  out  [Q] network-2 committed spikes, held between commits
//   valid1          out  one-cycle pulse when output_spikes1 updates
//   valid2          out  one-cycle pulse when output_spikes2 updates
//   active_net      out  0: window owned by network 1, 1: by network 2
//   spike_time1     out  [Q][TRES] network-1 first-spike times (macro only)
//   spike_time2     out  [Q][TRES] network-2 first-spike times (macro only)
//
// Optional feature macro: COLUMN_DEMUX_SPIKE_TIME_EN
// -----------------------------------------------------------------------------
module column_output_demux
    import mux_col_pkg::*;
#(
    parameter int Q    = DEFAULT_Q,
    parameter int TRES = DEFAULT_TRES
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    grst,
    input  logic [Q-1:0]            col_spikes,
    output logic [Q-1:0]            output_spikes1,
    output logic [Q-1:0]            output_spikes2,
    output logic                    valid1,
    output logic                    valid2,
    output logic                    active_net
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    ,
    output logic [Q-1:0][TRES-1:0]  spike_time1,
    output logic [Q-1:0][TRES-1:0]  spike_time2
`endif
);

    // Saturation value of the window counter; equals the "no spike" code.
    localparam logic [TRES-1:0] L_TSAT = {TRES{NO_SPIKE_BIT}};

    state_t          r_state;
    logic            r_active_net;
    logic [NNET-1:0] r_valid;
    logic [Q-1:0]    r_bank [NNET];
    logic [TRES-1:0] r_tcount;

    logic            w_running;
    logic            w_cap_en;
    logic [Q-1:0]    w_latch;

    assign w_running = (r_state != IDLE);
    // Spikes arriving with grst are dropped: the column is being reset then.
    assign w_cap_en  = w_running & ~grst;

`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    logic [Q-1:0][TRES-1:0] w_stamps;
    logic [Q-1:0][TRES-1:0] r_tbank [NNET];
`endif

    // -------------------------------------------------------------------------
    // Sticky capture of the current window
    // -------------------------------------------------------------------------
    spike_capture #(
        .Q      (Q)
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
        ,
        .TRES   (TRES)
`endif
    ) u_capture (
        .clk    (clk),
        .rstb   (rstb),
        .clr    (grst),
        .en     (w_cap_en),
        .spikes (col_spikes),
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
        .tcount (r_tcount),
`endif
        .latch  (w_latch)
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
        ,
        .stamps (w_stamps)
`endif
    );

    // -------------------------------------------------------------------------
    // In-window time counter: 0 on the first cycle after grst, saturating.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_tcount <= '0;
        end else if (grst) begin
            r_tcount <= '0;
        end else if (w_running && (r_tcount != L_TSAT)) begin
            r_tcount <= r_tcount + TRES'(1);
        end
    end

`ifndef COLUMN_DEMUX_SPIKE_TIME_EN
    // Without time stamping the counter only tracks window progress.
    logic w_unused_tcount;
    assign w_unused_tcount = ^r_tcount;
`endif

    // -------------------------------------------------------------------------
    // Window-ownership FSM with commit of the captured vector.
    // Bank index 0 belongs to network 1, index 1 to network 2.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= IDLE;
            r_active_net <= 1'b0;
            r_valid      <= '0;
            // NOTE: the held banks are small register arrays that drive
            // outputs directly, so they are reset explicitly; a held output
            // must never show stale data after a reset.
            for (int n = 0; n < NNET; n++) begin
                r_bank[n] <= '0;
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
                r_tbank[n] <= {(Q*TRES){NO_SPIKE_BIT}};
`endif
            end
        end else begin
            r_valid <= '0;
            if (grst) begin
                case (r_state)
                    IDLE: begin
                        // First window after reset always belongs to network 1.
                        r_state      <= RUN_N1;
                        r_active_net <= 1'b0;
                    end
                    RUN_N1: begin
                        r_bank[0]    <= w_latch;
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
                        r_tbank[0]   <= w_stamps;
`endif
                        r_valid[0]   <= 1'b1;
                        r_state      <= RUN_N2;
                        r_active_net <= 1'b1;
                    end
                    RUN_N2: begin
                        r_bank[1]    <= w_latch;
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
                        r_tbank[1]   <= w_stamps;
`endif
                        r_valid[1]   <= 1'b1;
                        r_state      <= RUN_N1;
                        r_active_net <= 1'b0;
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_active_net <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign output_spikes1 = r_bank[0];
    assign output_spikes2 = r_bank[1];
    assign valid1         = r_valid[0];
    assign valid2         = r_valid[1];
    assign active_net     = r_active_net;

`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    assign spike_time1 = r_tbank[0];
    assign spike_time2 = r_tbank[1];
`endif

endmodule : column_output_demux

// File: tb/tb_column_output_demux.sv
// -----------------------------------------------------------------------------
// tb_column_output_demux
//
// Directed stimulus with a window-level behavioural model. The model tracks
// windows as "started / which network / set of neurons seen / cycles elapsed"
// and is compared with the DUT on every falling edge; literal expectations
// pin the model on the scenarios that matter.
// -----------------------------------------------------------------------------
module tb_column_output_demux;

    localparam int Q    = 2;
    localparam int TRES = 3;
    localparam int TMAX = (1 << TRES) - 1;

    logic         clk;
    logic         rstb;
    logic         grst;
    logic [Q-1:0] col_spikes;
    logic [Q-1:0] output_spikes1;
    logic [Q-1:0] output_spikes2;
    logic         valid1;
    logic         valid2;
    logic         active_net;
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
    logic [Q-1:0][TRES-1:0] spike_time1;
    logic [Q-1:0][TRES-1:0] spike_time2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_on = 1'b0;

    column_output_demux #(
        .Q    (Q),
        .TRES (TRES)
    ) dut (
        .clk            (clk),
        .rstb           (rstb),
        .grst           (grst),
        .col_spikes     (col_spikes),
        .output_spikes1 (output_spikes1),
        .output_spikes2 (output_spikes2),
        .valid1         (valid1),
        .valid2         (valid2),
        .active_net     (active_net)
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
        ,
        .spike_time1    (spike_time1),
        .spike_time2    (spike_time2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level model ----------------
    logic         m_run   = 1'b0;   // a window has been opened since reset
    int           m_net   = 0;      // 0: network 1 owns the window, 1: network 2
    logic [Q-1:0] m_cap   = '0;     // neurons seen firing in this window
    int           m_cyc   = 0;      // cycles elapsed since the window opened
    int           m_stamp [Q];
    logic [Q-1:0] m_out   [2];
    logic [1:0]   m_val   = '0;
    int           m_tout  [2][Q];

    task automatic model_clear();
        m_run = 1'b0;
        m_net = 0;
        m_cap = '0;
        m_cyc = 0;
        m_val = '0;
        for (int n = 0; n < 2; n++) begin
            m_out[n] = '0;
            for (int q = 0; q < Q; q++) m_tout[n][q] = TMAX;
        end
        for (int q = 0; q < Q; q++) m_stamp[q] = TMAX;
    endtask

    initial model_clear();

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            model_clear();
        end else begin
            m_val = '0;
            if (grst) begin
                if (m_run) begin
                    m_out[m_net] = m_cap;
                    for (int q = 0; q < Q; q++) m_tout[m_net][q] = m_stamp[q];
                    m_val[m_net] = 1'b1;
                    m_net = 1 - m_net;
                end else begin
                    m_run = 1'b1;
                    m_net = 0;
                end
                m_cap = '0;
                m_cyc = 0;
                for (int q = 0; q < Q; q++) m_stamp[q] = TMAX;
            end else if (m_run) begin
                for (int q = 0; q < Q; q++) begin
                    if (col_spikes[q] && !m_cap[q]) begin
                        m_cap[q]   = 1'b1;
                        m_stamp[q] = (m_cyc > TMAX) ? TMAX : m_cyc;
                    end
                end
                m_cyc++;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("cmp_out1",   output_spikes1, m_out[0]);
            check("cmp_out2",   output_spikes2, m_out[1]);
            check("cmp_valid1", valid1, m_val[0]);
            check("cmp_valid2", valid2, m_val[1]);
            check("cmp_active", active_net, (m_run && m_net == 1));
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
            for (int q = 0; q < Q; q++) begin
                check($sformatf("cmp_st1[%0d]", q), spike_time1[q], m_tout[0][q]);
                check($sformatf("cmp_st2[%0d]", q), spike_time2[q], m_tout[1][q]);
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic g, input logic [Q-1:0] s);
        grst       = g;
        col_spikes = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [Q-1:0] o1, input logic [Q-1:0] o2,
                             input logic v1, input logic v2, input logic an);
        check({tag, "_out1"},   output_spikes1, o1);
        check({tag, "_out2"},   output_spikes2, o2);
        check({tag, "_valid1"}, valid1, v1);
        check({tag, "_valid2"}, valid2, v2);
        check({tag, "_active"}, active_net, an);
    endtask

    initial begin
        rstb       = 1'b0;
        grst       = 1'b0;
        col_spikes = 2'b11;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        step(1'b0, 2'b11);
        check_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Idle after reset: spikes ignored, nothing committed.
        rstb = 1'b1;
        repeat (3) step(1'b0, 2'b11);
        check_all("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Basic alternation: network-1 window with neuron 0 firing.
        step(1'b1, 2'b00);
        check("open_n1_active", active_net, 1'b0);
        step(1'b0, 2'b01);
        repeat (6) step(1'b0, 2'b00);
        step(1'b1, 2'b00);
        check_all("commit_n1", 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00);
        check("valid1_single_pulse", valid1, 1'b0);

        // Network-2 window with neuron 1 firing.
        step(1'b0, 2'b10);
        repeat (3) step(1'b0, 2'b00);
        step(1'b1, 2'b00);
        check_all("commit_n2", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);

        // Boundary: spike only in the grst cycle is dropped on both sides.
        repeat (3) step(1'b0, 2'b00);
        step(1'b1, 2'b10);
        check_all("bnd_commit_n1", 2'b00, 2'b10, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 2'b00);
        step(1'b1, 2'b00);
        check_all("bnd_next_n2", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

        // Back-to-back grst: window of length 1 commits zeros, valid still pulses.
        step(1'b0, 2'b11);
        step(1'b1, 2'b00);
        check_all("b2b_first", 2'b11, 2'b00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b00);
        check_all("b2b_second", 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);

        // Mid-window reset while network 2 holds a capture of 2'b11.
        step(1'b0, 2'b01);
        step(1'b1, 2'b00);
        step(1'b0, 2'b11);
        step(1'b0, 2'b00);
        check_all("pre_rst", 2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
        rstb = 1'b0;
        #1;
        check_all("async_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        rstb = 1'b1;
        step(1'b0, 2'b11);
        step(1'b1, 2'b00);
        check("post_rst_net1", active_net, 1'b0);
        step(1'b0, 2'b10);
        step(1'b1, 2'b00);
        check_all("post_rst_commit", 2'b10, 2'b00, 1'b1, 1'b0, 1'b1);

        // Spike-time windows: neuron 0 at cycle 2 in network 1,
        // neuron 1 at cycle 10 (saturated) in network 2.
        step(1'b1, 2'b00);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        step(1'b0, 2'b01);
        repeat (7) step(1'b0, 2'b00);
        step(1'b1, 2'b00);
        check_all("time_n1", 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
        check("st1_n0_cycle2", spike_time1[0], 3'd2);
        check("st1_n1_nospike", spike_time1[1], 3'd7);
`endif
        repeat (10) step(1'b0, 2'b00);
        step(1'b0, 2'b10);
        step(1'b1, 2'b00);
        check_all("time_n2", 2'b01, 2'b10, 1'b0, 1'b1, 1'b0);
`ifdef COLUMN_DEMUX_SPIKE_TIME_EN
        check("st2_n1_saturated", spike_time2[1], 3'd7);
        check("st2_n0_nospike", spike_time2[0], 3'd7);
`endif
        repeat (3) step(1'b0, 2'b00);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_column_output_demux
